// File: rtl/tdc_pkt_ser.sv
// TDC reading serialiser: one AXI-S word in, framed byte packet out.
// Frame = SYNC, SEQ, NBYTES payload (LSB first), CSUM (tlast).
module tdc_pkt_ser #(
  parameter int          DATA_WIDTH = 96,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
  input  logic                  i_s_axis_tvalid,
  output logic                  o_s_axis_tready,
  output logic [7:0]            o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready,
  output logic                  o_m_axis_tlast,
  output logic                  o_busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_PAY,
    S_CSUM
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            seq_q,   seq_d;
  logic [7:0]            csum_q,  csum_d;
  logic [DATA_WIDTH-1:0] sh_q,    sh_d;
  logic [CW-1:0]         cnt_q,   cnt_d;

  logic s_hs;
  logic m_hs;

  assign o_s_axis_tready = (state_q == S_IDLE);
  assign o_m_axis_tvalid = (state_q != S_IDLE);
  assign o_busy          = (state_q != S_IDLE);
  assign o_m_axis_tlast  = (state_q == S_CSUM);

  assign s_hs = i_s_axis_tvalid && o_s_axis_tready;
  assign m_hs = o_m_axis_tvalid && i_m_axis_tready;

  // Output byte is a pure function of registered state, so it holds on stalls.
  always_comb begin
    o_m_axis_tdata = 8'h00;
    unique case (state_q)
      S_HDR:   o_m_axis_tdata = SYNC_BYTE;
      S_SEQ:   o_m_axis_tdata = seq_q;
      S_PAY:   o_m_axis_tdata = sh_q[7:0];
      S_CSUM:  o_m_axis_tdata = csum_q;
      default: o_m_axis_tdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_hs) begin
          sh_d    = i_s_axis_tdata;
          csum_d  = 8'h00;
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (m_hs) state_d = S_SEQ;
      end
      S_SEQ: begin
        if (m_hs) begin
          csum_d  = csum_q + seq_q;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (m_hs) begin
          csum_d = csum_q + sh_q[7:0];
          sh_d   = sh_q >> 8;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (m_hs) begin
          seq_d   = seq_q + 8'h01;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      seq_q   <= 8'h00;
      csum_q  <= 8'h00;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tdc_pkt_ser.sv
// Directed bench for tdc_pkt_ser: framing, stalls, backpressure,
// sequence wrap and mid-packet reset.
module tb_tdc_pkt_ser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;

  always #5 clk = ~clk;

  tdc_pkt_ser #(.DATA_WIDTH(96), .SYNC_BYTE(8'hA5)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tdata  (s_tdata),
    .i_s_axis_tvalid (s_tvalid),
    .o_s_axis_tready (s_tready),
    .o_m_axis_tdata  (m_tdata),
    .o_m_axis_tvalid (m_tvalid),
    .i_m_axis_tready (m_tready),
    .o_m_axis_tlast  (m_tlast),
    .o_busy          (busy)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] rx      [0:31];
  logic       rx_last [0:31];
  int         rx_n;
  int         rx_cyc;

  logic [95:0] ones = {96{1'b1}};
  logic [95:0] w1   = {32'h3, 32'h2, 32'h1};
  logic [95:0] w2   = 96'hDEADBEEF_01234567_89ABCDEF;
  logic [95:0] w5   = 96'h0C0B0A09_08070605_04030201;
  logic [7:0]  t1_exp [0:14] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00,
                                 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                                 8'h03, 8'h00, 8'h00, 8'h00, 8'h06};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [95:0] w);
    int t;
    t = 0;
    @(negedge clk);
    s_tdata  = w;
    s_tvalid = 1'b1;
    while (!s_tready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(t < 100), 1);
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("lat1_valid", 32'(m_tvalid), 1);
    chk("lat1_hdr", 32'(m_tdata), 32'hA5);
  endtask

  task automatic collect(input bit rnd);
    int         t;
    bit         done;
    bit         pst;
    logic [7:0] pd;
    logic       pl;
    int         stall_err;
    int         flag_err;
    rx_n = 0; done = 0; pst = 0; t = 0;
    pd = 8'h00; pl = 1'b0;
    stall_err = 0; flag_err = 0;
    while (!done && t < 400) begin
      if (pst && (m_tdata !== pd || m_tlast !== pl)) stall_err++;
      if (s_tready !== 1'b0 || busy !== 1'b1 || m_tvalid !== 1'b1)
        flag_err++;
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pst = m_tvalid && !m_tready;
      pd  = m_tdata;
      pl  = m_tlast;
      if (m_tvalid && m_tready) begin
        rx[rx_n]      = m_tdata;
        rx_last[rx_n] = m_tlast;
        if (m_tlast) done = 1;
        if (rx_n < 31) rx_n++;
      end
      @(negedge clk);
      t++;
    end
    rx_cyc = t;
    chk("pkt_done", 32'(done), 1);
    chk("stall_stable", 32'(stall_err), 0);
    chk("busy_flags", 32'(flag_err), 0);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] seq,
                           input logic [95:0] w);
    logic [7:0] exp [0:14];
    logic [7:0] s;
    exp[0] = 8'hA5;
    exp[1] = seq;
    s = seq;
    for (int i = 0; i < 12; i++) begin
      exp[2+i] = w[8*i +: 8];
      s = s + w[8*i +: 8];
    end
    exp[14] = s;
    chk({tag, "_len"}, 32'(rx_n), 15);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(rx[i]), 32'(exp[i]));
      chk($sformatf("%s_l%0d", tag, i), 32'(rx_last[i]), 32'(i == 14));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sready", 32'(s_tready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: hand vector, no backpressure
    send(w1);
    collect(0);
    chk("t1_len", 32'(rx_n), 15);
    chk("t1_cycles", 32'(rx_cyc), 15);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t1_b%0d", i), 32'(rx[i]), 32'(t1_exp[i]));
      chk($sformatf("t1_l%0d", i), 32'(rx_last[i]), 32'(i == 14));
    end
    chk("t1_idle_sready", 32'(s_tready), 1);
    chk("t1_idle_valid", 32'(m_tvalid), 0);

    // 2: random downstream stalls
    send(w1);
    collect(1);
    check_pkt("t2", 8'h01, w1);

    // 3: second word held during packet
    send(w1);
    s_tdata  = w2;
    s_tvalid = 1'b1;
    collect(0);
    check_pkt("t3a", 8'h02, w1);
    chk("t3_sready_after", 32'(s_tready), 1);
    chk("t3_busy_after", 32'(busy), 0);
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("t3_hdr_valid", 32'(m_tvalid), 1);
    chk("t3_hdr", 32'(m_tdata), 32'hA5);
    collect(0);
    check_pkt("t3b", 8'h03, w2);

    // 4: sequence wrap with all-ones payload
    do_reset();
    for (int p = 0; p < 257; p++) begin
      send(ones);
      collect(0);
      check_pkt($sformatf("t4p%0d", p), 8'(p), ones);
      if (p == 0) chk("t4_csum00", 32'(rx[14]), 32'hF4);
      if (p == 255) chk("t4_csumFF", 32'(rx[14]), 32'hF3);
      if (p == 256) begin
        chk("t4_wrap_seq", 32'(rx[1]), 32'h00);
        chk("t4_wrap_csum", 32'(rx[14]), 32'hF4);
      end
    end

    // 5: reset in the middle of the payload
    send(w5);
    m_tready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_pay4", 32'(m_tdata), 32'h05);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(m_tvalid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_sready", 32'(s_tready), 1);
    send(w5);
    collect(0);
    check_pkt("t5", 8'h00, w5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
